// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//
// Program-counter sequencer for the ARM-subset core. Owns the architectural
// flag register and drives an external clocked Bcc condition checker to
// resolve conditional branches. One decoded instruction is accepted per cycle
// over a valid/ready handshake. Non-branches advance the PC by 4. A branch
// takes two cycles (accept + EVAL). A taken branch redirects the PC, pulses
// flush and, for BL, writes the link register.
//
// Ports:
//   clk, not_reset         clock, asynchronous active-low reset
//   stall                  back-end hold (blocks acceptance in RUN only)
//   instr_valid/ready      decode handshake
//   instr_is_branch        B/BL
//   instr_link             BL
//   instr_cond             ARM condition field
//   instr_offset           signed word offset (OFF_W bits)
//   flags_we, flags_in     ALU flag write, ordered [Z, C, N, V]
//   bcc_not_enable         active-low enable to Bcc
//   bcc_cond, bcc_flags    condition and flags presented to Bcc
//   bcc_ok                 Bcc result, valid the cycle after sampling
//   pc                     current fetch PC
//   flush                  one-cycle pulse after a taken branch
//   lr_we, lr_data         one-cycle link-register write
//   branch_cnt, taken_cnt  saturating performance counters
// -----------------------------------------------------------------------------
module branch_sequencer #(
    parameter int              PC_W     = 32,
    parameter int              OFF_W    = 24,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             not_reset,
    input  logic             stall,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_is_branch,
    input  logic             instr_link,
    input  logic [3:0]       instr_cond,
    input  logic [OFF_W-1:0] instr_offset,
    input  logic             flags_we,
    input  logic [3:0]       flags_in,
    output logic             bcc_not_enable,
    output logic [3:0]       bcc_cond,
    output logic [3:0]       bcc_flags,
    input  logic             bcc_ok,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             lr_we,
    output logic [PC_W-1:0]  lr_data,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

    localparam logic [3:0] COND_AL = 4'b1110;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [3:0]         flags_q;
    logic [PC_W-1:0]    target_q, target_d;
    logic [PC_W-1:0]    link_q, link_d;
    logic               link_flag_q, link_flag_d;
    logic [3:0]         cond_q, cond_d;
    logic [3:0]         bflags_q, bflags_d;
    logic               flush_q, flush_d;
    logic               lr_we_q, lr_we_d;
    logic [PC_W-1:0]    lr_data_q, lr_data_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

    logic               accept;
    logic [3:0]         flags_eff;
    logic [PC_W-1:0]    off_ext;
    logic [PC_W-1:0]    target_calc;
    logic [PC_W-1:0]    link_calc;

    // Word offset scaled to bytes and sign-extended (or truncated) to PC_W.
    for (genvar gi = 0; gi < PC_W; gi++) begin : g_off_ext
        if (gi < 2) begin : g_zero
            assign off_ext[gi] = 1'b0;
        end else if (gi - 2 < OFF_W) begin : g_bit
            assign off_ext[gi] = instr_offset[gi-2];
        end else begin : g_sign
            assign off_ext[gi] = instr_offset[OFF_W-1];
        end
    end

    // Branch target is relative to pc + 8 (ARM pipeline view); modulo 2^PC_W.
    assign target_calc = pc_q + PC_W'(8) + off_ext;
    assign link_calc   = pc_q + PC_W'(4);

    // Same-cycle flag write is forwarded to Bcc; otherwise the stored flags.
    assign flags_eff = flags_we ? flags_in : flags_q;

    // Held low during reset so decode never sees a handshake mid-reset.
    assign instr_ready = not_reset & (state_q == ST_RUN) & ~stall;
    assign accept      = instr_valid & instr_ready;

    // Flag register: written in any state.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            flags_q <= 4'b0000;
        end else if (flags_we) begin
            flags_q <= flags_in;
        end
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            target_q     <= '0;
            link_q       <= '0;
            link_flag_q  <= 1'b0;
            cond_q       <= COND_AL;
            bflags_q     <= 4'b0000;
            flush_q      <= 1'b0;
            lr_we_q      <= 1'b0;
            lr_data_q    <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            link_q       <= link_d;
            link_flag_q  <= link_flag_d;
            cond_q       <= cond_d;
            bflags_q     <= bflags_d;
            flush_q      <= flush_d;
            lr_we_q      <= lr_we_d;
            lr_data_q    <= lr_data_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        target_d       = target_q;
        link_d         = link_q;
        link_flag_d    = link_flag_q;
        cond_d         = cond_q;
        bflags_d       = bflags_q;
        flush_d        = 1'b0;
        lr_we_d        = 1'b0;
        lr_data_d      = lr_data_q;
        branch_cnt_d   = branch_cnt_q;
        taken_cnt_d    = taken_cnt_q;
        bcc_not_enable = 1'b1;
        bcc_cond       = cond_q;
        bcc_flags      = bflags_q;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (instr_is_branch) begin
                        target_d       = target_calc;
                        link_d         = link_calc;
                        link_flag_d    = instr_link;
                        cond_d         = instr_cond;
                        bflags_d       = flags_eff;
                        // Bcc samples these on the accept edge.
                        bcc_not_enable = 1'b0;
                        bcc_cond       = instr_cond;
                        bcc_flags      = flags_eff;
                        state_d        = ST_EVAL;
                    end else begin
                        pc_d = link_calc;
                    end
                end
            end

            ST_EVAL: begin
                // Inputs held stable; a flag write here only touches flags_q.
                bcc_not_enable = 1'b0;
                branch_cnt_d   = (&branch_cnt_q) ? branch_cnt_q
                                                 : branch_cnt_q + CNT_W'(1);
                if (bcc_ok) begin
                    pc_d        = target_q;
                    flush_d     = 1'b1;
                    taken_cnt_d = (&taken_cnt_q) ? taken_cnt_q
                                                 : taken_cnt_q + CNT_W'(1);
                    if (link_flag_q) begin
                        lr_we_d   = 1'b1;
                        lr_data_d = link_q;
                    end
                end else begin
                    pc_d = link_q;
                end
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc         = pc_q;
    assign flush      = flush_q;
    assign lr_we      = lr_we_q;
    assign lr_data    = lr_data_q;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_sequencer
//
// Scoreboard bench for branch_sequencer. Each driven instruction pushes its
// expected architectural result (pc, flush, lr_we, lr_data, counters) into a
// queue; the entry is popped and compared when the instruction retires.
// A small clocked model stands in for the external Bcc checker.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_sequencer;

    localparam int          PC_W   = 32;
    localparam int          OFF_W  = 24;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic             clk             = 1'b0;
    logic             not_reset       = 1'b0;
    logic             stall           = 1'b0;
    logic             instr_valid     = 1'b0;
    logic             instr_is_branch = 1'b0;
    logic             instr_link      = 1'b0;
    logic [3:0]       instr_cond      = 4'hE;
    logic [OFF_W-1:0] instr_offset    = '0;
    logic             flags_we        = 1'b0;
    logic [3:0]       flags_in        = 4'h0;
    logic             bcc_ok          = 1'b0;
    logic             instr_ready;
    logic             bcc_not_enable;
    logic [3:0]       bcc_cond;
    logic [3:0]       bcc_flags;
    logic [PC_W-1:0]  pc;
    logic             flush;
    logic             lr_we;
    logic [PC_W-1:0]  lr_data;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    branch_sequencer #(
        .PC_W     (PC_W),
        .OFF_W    (OFF_W),
        .RESET_PC (RST_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .not_reset       (not_reset),
        .stall           (stall),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_is_branch (instr_is_branch),
        .instr_link      (instr_link),
        .instr_cond      (instr_cond),
        .instr_offset    (instr_offset),
        .flags_we        (flags_we),
        .flags_in        (flags_in),
        .bcc_not_enable  (bcc_not_enable),
        .bcc_cond        (bcc_cond),
        .bcc_flags       (bcc_flags),
        .bcc_ok          (bcc_ok),
        .pc              (pc),
        .flush           (flush),
        .lr_we           (lr_we),
        .lr_data         (lr_data),
        .branch_cnt      (branch_cnt),
        .taken_cnt       (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        lr_we;
        logic [31:0] lr_data;
        logic [3:0]  bcnt;
        logic [3:0]  tcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;

    logic [31:0] m_pc      = RST_PC;
    logic [3:0]  m_flags   = 4'h0;
    logic [31:0] m_lr_data = 32'h0;
    logic [3:0]  m_bcnt    = 4'h0;
    logic [3:0]  m_tcnt    = 4'h0;

    // Flags ordered [Z, C, N, V].
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic z, cf, n, v;
        z = f[3]; cf = f[2]; n = f[1]; v = f[0];
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cf;
            4'h3:    return !cf;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cf && !z;
            4'h9:    return !cf || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'h1;
    endfunction

    // Stand-in for the clocked Bcc checker: result one cycle after sampling.
    always @(posedge clk) begin
        bcc_ok <= (!bcc_not_enable) ? cond_ok(bcc_cond, bcc_flags) : 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc      = m_pc;
        e.flush   = 1'b0;
        e.lr_we   = 1'b0;
        e.lr_data = m_lr_data;
        e.bcnt    = m_bcnt;
        e.tcnt    = m_tcnt;
        exp_q.push_back(e);
    endtask

    task automatic retire(input string tag, input logic fl, input logic lw);
        exp_t e;
        check_val({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            e.flush = fl;
            e.lr_we = lw;
            n_txn++;
            $display("txn %0d %s: pc=%08h flush=%0b lr_we=%0b lr_data=%08h bcnt=%0d tcnt=%0d",
                     n_txn, tag, pc, flush, lr_we, lr_data, branch_cnt, taken_cnt);
            check_val({tag, "_pc"},      pc,                e.pc);
            check_val({tag, "_flush"},   32'(flush),        32'(e.flush));
            check_val({tag, "_lr_we"},   32'(lr_we),        32'(e.lr_we));
            check_val({tag, "_lr_data"}, lr_data,           e.lr_data);
            check_val({tag, "_bcnt"},    32'(branch_cnt),   32'(e.bcnt));
            check_val({tag, "_tcnt"},    32'(taken_cnt),    32'(e.tcnt));
        end
    endtask

    task automatic issue_nonbranch();
        instr_valid     = 1'b1;
        instr_is_branch = 1'b0;
        instr_link      = 1'b0;
        m_pc            = m_pc + 32'd4;
        push_exp();
        #1;
        check_val("nb_ready", 32'(instr_ready), 32'd1);
        check_val("nb_bcc_ne", 32'(bcc_not_enable), 32'd1);
        tick();
        instr_valid = 1'b0;
        retire("nb", 1'b0, 1'b0);
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_we = 1'b1;
        flags_in = f;
        m_flags  = f;
        tick();
        flags_we = 1'b0;
    endtask

    // Drives a branch through accept and EVAL. During EVAL the bench holds
    // stall and instr_valid high, which must be ignored, and may write flags.
    task automatic issue_branch(input logic [3:0] cond, input logic [23:0] off,
                                input logic lnk, input logic fwe,
                                input logic [3:0] fin, input logic ewe,
                                input logic [3:0] ein);
        logic [3:0]  eff;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] lnkv;
        instr_valid     = 1'b1;
        instr_is_branch = 1'b1;
        instr_link      = lnk;
        instr_cond      = cond;
        instr_offset    = off;
        flags_we        = fwe;
        flags_in        = fin;
        eff     = fwe ? fin : m_flags;
        m_flags = eff;
        tk      = cond_ok(cond, eff);
        tgt     = m_pc + 32'd8 + {{6{off[23]}}, off, 2'b00};
        lnkv    = m_pc + 32'd4;
        m_bcnt  = sat_inc(m_bcnt);
        if (tk) m_tcnt = sat_inc(m_tcnt);
        if (tk && lnk) m_lr_data = lnkv;
        m_pc = tk ? tgt : lnkv;
        push_exp();
        #1;
        check_val("acc_ready", 32'(instr_ready), 32'd1);
        check_val("acc_bcc_ne", 32'(bcc_not_enable), 32'd0);
        check_val("acc_bcc_cond", 32'(bcc_cond), 32'(cond));
        check_val("acc_bcc_flags", 32'(bcc_flags), 32'(eff));
        tick();
        instr_is_branch = 1'b0;
        stall           = 1'b1;
        flags_we        = ewe;
        flags_in        = ein;
        #1;
        check_val("ev_ready", 32'(instr_ready), 32'd0);
        check_val("ev_bcc_ne", 32'(bcc_not_enable), 32'd0);
        check_val("ev_bcc_cond", 32'(bcc_cond), 32'(cond));
        check_val("ev_bcc_flags", 32'(bcc_flags), 32'(eff));
        check_val("ev_flush", 32'(flush), 32'd0);
        if (ewe) m_flags = ein;
        tick();
        instr_valid = 1'b0;
        stall       = 1'b0;
        flags_we    = 1'b0;
        check_val("post_bcc_ne", 32'(bcc_not_enable), 32'd1);
        retire("br", tk, tk && lnk);
    endtask

    task automatic goto_addr(input logic [31:0] addr);
        logic [31:0] d;
        d = addr - m_pc - 32'd8;
        issue_branch(4'hE, d[25:2], 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while held in reset.
        repeat (2) tick();
        check_val("rst_pc", pc, RST_PC);
        check_val("rst_ready", 32'(instr_ready), 32'd0);
        check_val("rst_bcc_ne", 32'(bcc_not_enable), 32'd1);
        check_val("rst_bcc_cond", 32'(bcc_cond), 32'hE);
        check_val("rst_bcc_flags", 32'(bcc_flags), 32'h0);
        check_val("rst_flush", 32'(flush), 32'd0);
        check_val("rst_lr_we", 32'(lr_we), 32'd0);
        check_val("rst_lr_data", lr_data, 32'h0);
        check_val("rst_bcnt", 32'(branch_cnt), 32'd0);
        check_val("rst_tcnt", 32'(taken_cnt), 32'd0);
        not_reset = 1'b1;
        tick();

        // Back-to-back non-branches: 0x104, 0x108, 0x10C.
        for (int i = 0; i < 3; i++) issue_nonbranch();

        // Stall with valid: nothing accepted, pc holds.
        stall       = 1'b1;
        instr_valid = 1'b1;
        #1;
        check_val("stall_ready", 32'(instr_ready), 32'd0);
        repeat (2) tick();
        check_val("stall_pc", pc, m_pc);
        stall       = 1'b0;
        instr_valid = 1'b0;

        // BEQ +2 at 0x200 with Z set: taken to 0x210, then an instruction
        // accepted in the flush cycle.
        goto_addr(32'h200);
        set_flags(4'b1111);
        issue_branch(4'h0, 24'd2, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        issue_nonbranch();

        // BEQ at 0x200 with Z clear: not taken, pc 0x204.
        goto_addr(32'h200);
        set_flags(4'b0110);
        issue_branch(4'h0, 24'd2, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        // BL AL -4 at 0x300: pc 0x2F8, link 0x304.
        goto_addr(32'h300);
        issue_branch(4'hE, 24'hFFFFFC, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        issue_nonbranch();

        // Bypass: old flags 1000, same-cycle write 0000, BNE taken; flag
        // write during EVAL must not disturb bcc_flags but lands in flags_q.
        set_flags(4'b1000);
        issue_branch(4'h1, 24'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111);
        issue_branch(4'h0, 24'd1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        // Reset dropped during EVAL of a BL.
        instr_valid     = 1'b1;
        instr_is_branch = 1'b1;
        instr_link      = 1'b1;
        instr_cond      = 4'hE;
        instr_offset    = 24'd5;
        tick();
        instr_valid     = 1'b0;
        instr_is_branch = 1'b0;
        instr_link      = 1'b0;
        #2;
        not_reset = 1'b0;
        #1;
        check_val("evrst_pc", pc, RST_PC);
        check_val("evrst_flush", 32'(flush), 32'd0);
        check_val("evrst_lr_we", 32'(lr_we), 32'd0);
        check_val("evrst_lr_data", lr_data, 32'h0);
        check_val("evrst_bcnt", 32'(branch_cnt), 32'd0);
        check_val("evrst_tcnt", 32'(taken_cnt), 32'd0);
        check_val("evrst_bcc_ne", 32'(bcc_not_enable), 32'd1);
        repeat (2) tick();
        not_reset = 1'b1;
        m_pc      = RST_PC;
        m_flags   = 4'h0;
        m_lr_data = 32'h0;
        m_bcnt    = 4'h0;
        m_tcnt    = 4'h0;
        tick();
        check_val("evrel_pc", pc, RST_PC);
        check_val("evrel_flush", 32'(flush), 32'd0);
        check_val("evrel_lr_we", 32'(lr_we), 32'd0);
        check_val("evrel_bcnt", 32'(branch_cnt), 32'd0);
        issue_nonbranch();

        // Offset extremes wrap modulo 2^32, then pc wrap through zero.
        issue_branch(4'hE, 24'h800000, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        issue_branch(4'hE, 24'h7FFFFF, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        goto_addr(32'hFFFF_FFFC);
        issue_nonbranch();

        // Not-taken BLs until branch_cnt saturates; no lr_we when not taken.
        set_flags(4'b0000);
        for (int i = 0; i < 16; i++) begin
            issue_branch(4'h0, 24'd4, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        end
        check_val("sat_bcnt", 32'(branch_cnt), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer for the ARM-subset core that owns the architectural flag register. It drives the clocked `Bcc` condition checker to resolve conditional branches. It accepts one decoded instruction at a time over a valid/ready handshake, advances the PC for non-branches, and holds the front end for one evaluation cycle per branch. When a branch is taken it redirects the PC, pulses flush and, for BL, writes the link register. It sits between the decode stage and fetch, beside the ALU that produces flags.

## Interface

Parameters:
- `PC_W`, default 32: PC and link width.
- `OFF_W`, default 24: signed branch word-offset width.
- `RESET_PC`, default 0: PC value after reset.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `not_reset`  in  1: asynchronous, active-low reset.
- `stall`  in  1: back-end hold; blocks acceptance while in RUN.
- `instr_valid`  in  1: decode presents an instruction.
- `instr_ready`  out  1: sequencer accepts the instruction.
- `instr_is_branch`  in  1: instruction is B/BL.
- `instr_link`  in  1: BL; writes the link register if taken.
- `instr_cond`  in  4: ARM condition field (0000 EQ … 1110 AL).
- `instr_offset`  in  OFF_W: signed word offset.
- `flags_we`  in  1: ALU flag write strobe.
- `flags_in`  in  4: flag value, ordered [Z, C, N, V].
- `bcc_not_enable`  out  1: active-low enable to `Bcc`.
- `bcc_cond`  out  4: condition to `Bcc`.
- `bcc_flags`  out  4: flags to `Bcc`, ordered [Z, C, N, V].
- `bcc_ok`  in  1: `Bcc` result; valid one cycle after the inputs are sampled.
- `pc`  out  PC_W: current fetch PC.
- `flush`  out  1: one-cycle pulse on a taken branch.
- `lr_we`  out  1: one-cycle link-register write strobe.
- `lr_data`  out  PC_W: link value.
- `branch_cnt`  out  CNT_W: branches evaluated, saturating.
- `taken_cnt`  out  CNT_W: branches taken, saturating.

## Operation

- Flag register `flags_q` (4 bits) loads `flags_in` on every cycle in which `flags_we=1`, in any state.
- Two states: RUN and EVAL.

RUN:
- `instr_ready = ~stall`. An instruction is accepted when `instr_valid & instr_ready`.
- Accepted non-branch: `pc <= pc + 4`. State stays RUN.
- Accepted branch, same edge:
  - Latch `target = pc + 8 + (sext(instr_offset) << 2)`.
  - Latch `link = pc + 4`, `instr_link` and `instr_cond`.
  - Drive the `Bcc` inputs (see below). Go to EVAL.
- The flags presented to `Bcc` are `flags_in` if `flags_we=1` in the accept cycle, otherwise `flags_q`. This bypass is the only forwarding path.
- `bcc_not_enable` is combinationally 0 in the accept cycle.
- `bcc_cond` and `bcc_flags` come from the current instruction in the accept cycle and from the latched copies during EVAL.

EVAL (exactly one cycle):
- `instr_ready = 0`.
- `bcc_not_enable = 0`, with `bcc_cond` and `bcc_flags` held at the latched values.
- Sample `bcc_ok`:
  - `bcc_ok=1`: `pc <= target`; `flush` high for the next cycle.
  - `bcc_ok=1` and link: `lr_we` high for the next cycle with `lr_data = link`.
  - `bcc_ok=0`: `pc <= link`; no flush, no `lr_we`.
- Always return to RUN.
- `stall` is ignored in EVAL. The branch always resolves.
- A `flags_we` during EVAL updates `flags_q` only. It never changes the in-flight `bcc_flags`.

General rules:
- `flush` and `lr_we` are registered pulses, high only in the cycle after EVAL.
- In the accept cycle the combinational `bcc_not_enable` is 0; after EVAL it deasserts to the reset value 1. The stable `Bcc` encodings are only 1 (idle) and 0 (evaluating).
- All PC arithmetic is modulo 2^PC_W; wrap-around is silent.
- `branch_cnt` increments in every EVAL cycle. `taken_cnt` increments when `bcc_ok=1` in EVAL. Both saturate at all-ones.

## Timing

Reset values (asynchronous, while `not_reset=0`):
- `pc = RESET_PC`, state RUN, `flags_q = 0`.
- `bcc_not_enable = 1`, `bcc_cond = 4'b1110`, `bcc_flags = 0`.
- `flush = 0`, `lr_we = 0`, `lr_data = 0`, both counters 0.
- `instr_ready = 0` while in reset; `~stall` after reset release.

Latency:
- Non-branch throughput: one instruction per cycle.
- Branch cost: two cycles (accept + EVAL). The next instruction is accepted in the cycle after EVAL, at the new `pc`, coincident with `flush`.

Boundary cases:
- Reset asserted during EVAL: the branch is abandoned with no flush, no `lr_we` and no counter update. `pc = RESET_PC`.
- `stall=1` with `instr_valid=1` in RUN: nothing is accepted and `pc` holds.
- Offset at its extremes (most negative, most positive): `target` wraps modulo 2^PC_W.

## Test plan

- Reset with `RESET_PC=0x100`; 3 back-to-back non-branches → `pc` = 0x104, 0x108, 0x10C; `instr_ready=1` throughout.
- `flags_in=1111`, `flags_we=1`, then BEQ offset=+2 at pc=0x200 → `bcc_cond=0000` in the accept cycle; `bcc_ok=1` in EVAL → `pc=0x210`, one-cycle `flush`, `taken_cnt=1`.
- Flags 0110, BEQ at pc=0x200 → `bcc_ok=0` → `pc=0x204`, no flush; `branch_cnt` +1, `taken_cnt` unchanged.
- BL AL offset=-4 at pc=0x300 → `pc=0x2F8`; `lr_we` pulse with `lr_data=0x304`.
- Branch accepted with `flags_we=1` and `flags_in=0000` in the same cycle, old flags 1000, BNE → `bcc_flags=0000` (bypass) and the branch is taken; a `flags_we` during EVAL leaves `bcc_flags` unchanged.
- `not_reset` dropped during EVAL → immediate `pc=RESET_PC`; no `flush`, no `lr_we`, counters 0.
